// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encodings, default datapath width, divide-by-zero result.
package alu_pkg;

    localparam int ALU_W     = 8;
    localparam int ALU_W_MAX = 16;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_t;

    // Quotient reported for a zero divisor; sliced down to the instance width.
    localparam logic [ALU_W_MAX-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/alu_sub.sv
// Combinational (WIDTH+1)-bit subtractor a-b with borrow out; shared by the divider and the SUB opcode.
module alu_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    logic [WIDTH+1:0] full;

    // One extra bit on top of both operands turns the carry-out into the borrow.
    assign full   = {1'b0, a} - {1'b0, b};
    assign diff   = full[WIDTH:0];
    assign borrow = full[WIDTH+1];

endmodule

// File: rtl/alu_div8.sv
// Unsigned restoring divider: result WIDTH+1 cycles after start (1 cycle for a zero divisor).
// No backpressure: start is dropped while busy; a start during the done cycle is accepted back-to-back.
module alu_div8
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] out_quot_q, out_quot_d;
    logic [WIDTH-1:0] out_rem_q, out_rem_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   rem_shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             accept;

    // Next bit of the dividend enters the partial remainder from the quotient register's MSB.
    assign rem_shifted = (rem_q << 1) | {{WIDTH{1'b0}}, quot_q[WIDTH-1]};

    alu_sub #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .a      (rem_shifted),
        .b      ({1'b0, div_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign accept = start && (state_q != DIV_RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        div_d      = div_q;
        out_quot_d = out_quot_q;
        out_rem_d  = out_rem_q;
        div_zero_d = div_zero_q;

        case (state_q)
            DIV_IDLE, DIV_FIN: begin
                state_d = DIV_IDLE;
                if (accept) begin
                    quot_d = in_a;
                    div_d  = in_b;
                    rem_d  = '0;
                    if (in_b == '0) begin
                        // Zero divisor resolves immediately without iterating.
                        state_d    = DIV_FIN;
                        cnt_d      = '0;
                        out_quot_d = DIV0_QUOT[WIDTH-1:0];
                        out_rem_d  = in_a;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d    = DIV_RUN;
                        cnt_d      = CNT_W'(WIDTH - 1);
                        div_zero_d = 1'b0;
                    end
                end
            end

            DIV_RUN: begin
                // Borrow means the trial went negative: keep the shifted remainder.
                rem_d  = borrow ? rem_shifted : trial;
                quot_d = {quot_q[WIDTH-2:0], ~borrow};
                if (cnt_q == '0) begin
                    state_d    = DIV_FIN;
                    out_quot_d = quot_d;
                    out_rem_d  = rem_d[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            div_q      <= '0;
            out_quot_q <= '0;
            out_rem_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            div_q      <= div_d;
            out_quot_q <= out_quot_d;
            out_rem_q  <= out_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == DIV_RUN);
    assign done     = (state_q == DIV_FIN);
    assign out_quot = out_quot_q;
    assign out_rem  = out_rem_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_div8.sv
// Bench for alu_div8: directed vectors with literal expectations plus a per-cycle arithmetic model.
module tb_alu_div8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] out_quot;
    logic [W-1:0] out_rem;
    logic         div_zero;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    alu_div8 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_a     (in_a),
        .in_b     (in_b),
        .busy     (busy),
        .done     (done),
        .out_quot (out_quot),
        .out_rem  (out_rem),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: results from / and %, timing as "WIDTH busy cycles then one done cycle".
    int           m_run = 0;
    bit           m_fin = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [W-1:0] p_q = '0, p_r = '0;
    logic [W-1:0] e_q = '0, e_r = '0;
    bit           e_dz = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 0;
            m_fin <= 1'b0;
            e_q   <= '0;
            e_r   <= '0;
            e_dz  <= 1'b0;
        end else if (m_run > 0) begin
            m_run <= m_run - 1;
            m_fin <= 1'b0;
            if (m_run == 1) begin
                m_fin <= 1'b1;
                e_q   <= p_q;
                e_r   <= p_r;
            end
        end else begin
            m_fin <= 1'b0;
            if (start) begin
                m_a <= in_a;
                m_b <= in_b;
                if (in_b == '0) begin
                    m_fin <= 1'b1;
                    e_q   <= '1;
                    e_r   <= in_a;
                    e_dz  <= 1'b1;
                end else begin
                    m_run <= W;
                    p_q   <= in_a / in_b;
                    p_r   <= in_a % in_b;
                    e_dz  <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_run > 0));
            chk("done", 32'(done), 32'(m_fin));
            chk("out_quot", 32'(out_quot), 32'(e_q));
            chk("out_rem", 32'(out_rem), 32'(e_rem_fix(e_r)));
            chk("div_zero", 32'(div_zero), 32'(e_dz));
            if (done && !div_zero) begin
                chk("inv_sum", int'(out_quot) * int'(m_b) + int'(out_rem), 32'(m_a));
                chk("inv_rem_lt_b", 32'(out_rem < m_b), 32'd1);
            end
        end
    end

    function automatic logic [W-1:0] e_rem_fix(input logic [W-1:0] r);
        return r;
    endfunction

    // Issues one start at the current negedge; returns cycles until done (-1 on timeout).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        @(negedge clk);
        start = 1'b0;
        in_a  = W'($urandom);
        in_b  = W'($urandom);
        lat   = -1;
        for (int k = 1; k <= 30; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic op_check(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eq, input logic [W-1:0] er,
                            input bit edz, input int elat);
        int lat;
        run_op(a, b, lat);
        chk("latency", 32'(lat), 32'(elat));
        chk("lit_quot", 32'(out_quot), 32'(eq));
        chk("lit_rem", 32'(out_rem), 32'(er));
        chk("lit_div_zero", 32'(div_zero), 32'(edz));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;
        int done_k;
        logic [W-1:0] cq, cr;
        logic [W-1:0] ra, rb;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", 32'(out_quot), 32'd0);
        chk("rst_rem", 32'(out_rem), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);

        op_check(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 9);
        op_check(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9);
        op_check(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9);
        op_check(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9);
        op_check(8'd13,  8'd0,   8'hFF,  8'd13, 1'b1, 1);
        op_check(8'd100, 8'd10,  8'd10,  8'd0,  1'b0, 9);
        op_check(8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 9);
        op_check(8'd128, 8'd2,   8'd64,  8'd0,  1'b0, 9);

        // Second start while running must be ignored.
        start = 1'b1; in_a = 8'd200; in_b = 8'd7;
        ndone = 0; done_k = -1; cq = '0; cr = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) begin
                start = 1'b1; in_a = 8'd50; in_b = 8'd5;
            end
            if (done) begin
                ndone++;
                done_k = k;
                cq = out_quot;
                cr = out_rem;
            end
        end
        start = 1'b0;
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_done_cycle", 32'(done_k), 32'd9);
        chk("ign_quot", 32'(cq), 32'd28);
        chk("ign_rem", 32'(cr), 32'd4);

        // Reset in the middle of an operation.
        start = 1'b1; in_a = 8'd200; in_b = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_quot", 32'(out_quot), 32'd0);
        chk("mid_rst_rem", 32'(out_rem), 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", 32'(ndone), 32'd0);
        op_check(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9);

        // Random sweep, mostly back-to-back with start asserted in the done cycle.
        for (int i = 0; i < 2000; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = W'($urandom_range(1, 3));
            run_op(ra, rb, lat);
            chk("rand_latency", 32'(lat), (rb == '0) ? 32'd1 : 32'd9);
            if ($urandom_range(0, 9) == 0) @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
